// File: rtl/io_stim_pkg.sv
// rtl/io_stim_pkg.sv - shared encodings for the I/O port stimulus engine
package io_stim_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'd0,
    MODE_INC  = 2'd1,
    MODE_LFSR = 2'd2,
    MODE_DEC  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEF_LFSR_TAPS = 32'h80200003;

endpackage

// File: rtl/stim_channel.sv
// rtl/stim_channel.sv - one stimulus channel: value register, period ticker, pattern step
module stim_channel
  import io_stim_pkg::*;
#(
  parameter int               WIDTH      = 32,
  parameter int               PER_W      = 16,
  parameter int               DEF_PERIOD = 5,
  parameter logic [WIDTH-1:0] RESET_VAL  = '0,
  parameter logic [WIDTH-1:0] TAPS       = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick_en_i,
  input  logic             clr_i,
  input  logic             cfg_load_i,
  input  mode_e            cfg_mode_i,
  input  logic [WIDTH-1:0] cfg_step_i,
  input  logic [WIDTH-1:0] cfg_seed_i,
  input  logic [PER_W-1:0] cfg_period_i,
  output logic [WIDTH-1:0] value_o,
  output logic             upd_o
);

  mode_e            mode_q;
  logic [WIDTH-1:0] step_q;
  logic [PER_W-1:0] period_q;
  logic [PER_W-1:0] tick_q;
  logic [WIDTH-1:0] value_q;
  logic             upd_q;
  logic [WIDTH-1:0] value_d;
  logic [PER_W-1:0] last_tick;

  // A period of 0 behaves like 1: the channel steps every cycle.
  assign last_tick = (period_q == '0) ? '0 : period_q - PER_W'(1);

  always_comb begin
    value_d = value_q;
    case (mode_q)
      MODE_INC:  value_d = value_q + step_q;
      MODE_DEC:  value_d = value_q - step_q;
      MODE_LFSR: value_d = {1'b0, value_q[WIDTH-1:1]} ^ (value_q[0] ? TAPS : '0);
      default:   value_d = value_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_q   <= MODE_INC;
      step_q   <= WIDTH'(1);
      period_q <= PER_W'(DEF_PERIOD);
      tick_q   <= '0;
      value_q  <= RESET_VAL;
      upd_q    <= 1'b0;
    end else begin
      upd_q <= 1'b0;
      if (cfg_load_i) begin
        mode_q   <= cfg_mode_i;
        step_q   <= cfg_step_i;
        period_q <= cfg_period_i;
        tick_q   <= '0;
        value_q  <= (cfg_mode_i == MODE_LFSR && cfg_seed_i == '0) ? WIDTH'(1) : cfg_seed_i;
      end else if (clr_i) begin
        tick_q <= '0;
      end else if (tick_en_i) begin
        if (tick_q >= last_tick) begin
          tick_q  <= '0;
          value_q <= value_d;
          upd_q   <= 1'b1;
        end else begin
          tick_q <= tick_q + PER_W'(1);
        end
      end
    end
  end

  assign value_o = value_q;
  assign upd_o   = upd_q;

endmodule

// File: rtl/io_port_stimulus.sv
// rtl/io_port_stimulus.sv - run FSM, config decode and output-port change monitor
module io_port_stimulus
  import io_stim_pkg::*;
#(
  parameter int          N_CH       = 2,
  parameter int          WIDTH      = 32,
  parameter int          PER_W      = 16,
  parameter int          CNT_W      = 16,
  parameter int          DEF_PERIOD = 5,
  parameter logic [31:0] LFSR_TAPS  = DEF_LFSR_TAPS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      run_len,
  input  logic                  cfg_we,
  input  logic [2:0]            cfg_ch,
  input  logic [1:0]            cfg_mode,
  input  logic [WIDTH-1:0]      cfg_step,
  input  logic [WIDTH-1:0]      cfg_seed,
  input  logic [PER_W-1:0]      cfg_period,
  output logic [N_CH*WIDTH-1:0] in_port,
  output logic [N_CH-1:0]       upd,
  input  logic [N_CH*WIDTH-1:0] out_port,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [CNT_W-1:0]      chg_cnt,
  output logic [WIDTH-1:0]      signature
);

  state_e                 state_q;
  logic [CNT_W-1:0]       upd_cnt_q;
  logic                   first_q;
  logic [N_CH*WIDTH-1:0]  shadow_q;
  logic [CNT_W-1:0]       chg_cnt_q;
  logic [WIDTH-1:0]       sig_q;
  logic                   cfg_err_q;
  logic                   ch_valid, cfg_ok, start_run, finish, tick_en;
  logic [WIDTH-1:0]       mix;

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] x, input int s);
    return (x << s) | (x >> (WIDTH - s));
  endfunction

  assign ch_valid  = {1'b0, cfg_ch} < 4'(N_CH);
  assign cfg_ok    = cfg_we && ch_valid && (state_q != ST_RUN);
  assign start_run = start && (state_q != ST_RUN);
  // Stop ticking on the last RUN cycle so exactly run_len ch0 updates happen.
  assign finish    = (state_q == ST_RUN) && upd[0] && (run_len != '0) &&
                     (upd_cnt_q + CNT_W'(1) == run_len);
  assign tick_en   = (state_q == ST_RUN) && !finish;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    stim_channel #(
      .WIDTH     (WIDTH),
      .PER_W     (PER_W),
      .DEF_PERIOD(DEF_PERIOD),
      .RESET_VAL (WIDTH'(k)),
      .TAPS      (WIDTH'(LFSR_TAPS))
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .tick_en_i   (tick_en),
      .clr_i       (start_run),
      .cfg_load_i  (cfg_ok && (cfg_ch == 3'(k))),
      .cfg_mode_i  (mode_e'(cfg_mode)),
      .cfg_step_i  (cfg_step),
      .cfg_seed_i  (cfg_seed),
      .cfg_period_i(cfg_period),
      .value_o     (in_port[k*WIDTH +: WIDTH]),
      .upd_o       (upd[k])
    );
  end

  always_comb begin
    mix = '0;
    for (int k = 0; k < N_CH; k++) begin
      mix = mix ^ rotl(out_port[k*WIDTH +: WIDTH], k % WIDTH);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      upd_cnt_q <= '0;
      first_q   <= 1'b0;
      shadow_q  <= '0;
      chg_cnt_q <= '0;
      sig_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !cfg_ok;
      case (state_q)
        ST_RUN: begin
          if (finish) state_q <= ST_DONE;
          if (upd[0]) upd_cnt_q <= upd_cnt_q + CNT_W'(1);
          shadow_q <= out_port;
          first_q  <= 1'b0;
          if (!first_q && (out_port != shadow_q)) begin
            if (chg_cnt_q != '1) chg_cnt_q <= chg_cnt_q + CNT_W'(1);
            sig_q <= rotl(sig_q, 1) ^ mix;
          end
        end
        default: begin
          if (start) begin
            state_q   <= ST_RUN;
            upd_cnt_q <= '0;
            chg_cnt_q <= '0;
            sig_q     <= '0;
            first_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign cfg_err   = cfg_err_q;
  assign chg_cnt   = chg_cnt_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_io_port_stimulus.sv
// tb/tb_io_port_stimulus.sv - randomized self-checking bench with a behavioural port model
module tb_io_port_stimulus;

  localparam int          N_CH  = 2;
  localparam int          WIDTH = 32;
  localparam int          PER_W = 16;
  localparam int          CNT_W = 16;
  localparam logic [31:0] TAPS  = 32'h80200003;

  logic                  clk = 1'b0;
  logic                  reset = 1'b1;
  logic                  start = 1'b0;
  logic [CNT_W-1:0]      run_len = '0;
  logic                  cfg_we = 1'b0;
  logic [2:0]            cfg_ch = '0;
  logic [1:0]            cfg_mode = '0;
  logic [WIDTH-1:0]      cfg_step = '0;
  logic [WIDTH-1:0]      cfg_seed = '0;
  logic [PER_W-1:0]      cfg_period = '0;
  logic [N_CH*WIDTH-1:0] in_port, out_port;
  logic [N_CH*WIDTH-1:0] ext_out = '0;
  logic [N_CH-1:0]       upd;
  logic                  busy, done, cfg_err;
  logic [CNT_W-1:0]      chg_cnt;
  logic [WIDTH-1:0]      signature;
  logic                  loop = 1'b0;

  always #5 clk = ~clk;

  assign out_port = loop ? in_port : ext_out;

  io_port_stimulus dut (
    .clock(clk), .reset(reset), .start(start), .run_len(run_len),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_step(cfg_step),
    .cfg_seed(cfg_seed), .cfg_period(cfg_period), .in_port(in_port), .upd(upd),
    .out_port(out_port), .busy(busy), .done(done), .cfg_err(cfg_err),
    .chg_cnt(chg_cnt), .signature(signature)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] m_val [N_CH];
  logic [WIDTH-1:0] m_step[N_CH];
  int               m_mode[N_CH];
  int               m_per [N_CH];
  int               m_chg;
  logic [WIDTH-1:0] m_sig;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rol32(input logic [31:0] x, input int s);
    logic [63:0] d;
    d = {x, x};
    return d[63-s -: 32];
  endfunction

  function automatic logic [WIDTH-1:0] next_val(input int mode, input logic [WIDTH-1:0] v,
                                                input logic [WIDTH-1:0] s);
    case (mode)
      1:       return v + s;
      2:       return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
      3:       return v - s;
      default: return v;
    endcase
  endfunction

  function automatic logic [63:0] exp_in();
    return {m_val[1], m_val[0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_CH; k++) begin
      m_val[k] = WIDTH'(k); m_step[k] = 1; m_mode[k] = 1; m_per[k] = 5;
    end
    m_chg = 0; m_sig = '0;
  endtask

  task automatic model_cfg(input int ch, input int mode, input logic [WIDTH-1:0] step,
                           input logic [WIDTH-1:0] seed, input int period);
    m_mode[ch] = mode;
    m_step[ch] = step;
    m_per[ch]  = (period == 0) ? 1 : period;
    m_val[ch]  = (mode == 2 && seed == 0) ? 1 : seed;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cfg(input int ch, input int mode, input logic [WIDTH-1:0] step,
                           input logic [WIDTH-1:0] seed, input int period);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_mode = 2'(mode);
    cfg_step = step; cfg_seed = seed; cfg_period = PER_W'(period);
  endtask

  task automatic cfg_write(input int ch, input int mode, input logic [WIDTH-1:0] step,
                           input logic [WIDTH-1:0] seed, input int period);
    bit bad;
    bad = (ch >= N_CH);
    drive_cfg(ch, mode, step, seed, period);
    tick();
    cfg_we = 1'b0;
    if (!bad) model_cfg(ch, mode, step, seed, period);
    check("cfg_err_pulse", 64'(cfg_err), 64'(bad));
    check("cfg_in_port", in_port, exp_in());
    tick();
    check("cfg_err_clear", 64'(cfg_err), 64'd0);
  endtask

  // Runs one stimulus run from IDLE/DONE; the model tracks values, update
  // timing and the monitor from the sequence of words presented to out_port.
  task automatic run(input int len, input bit lb, input int max_cyc, input int bad_t);
    int               p0, tend;
    bit               have_prev;
    logic [63:0]      cur, prev;
    logic [N_CH-1:0]  eu;
    p0   = m_per[0];
    tend = (len == 0) ? max_cyc : p0 * len + 1;
    loop = lb; run_len = CNT_W'(len);
    start = 1'b1;
    tick();
    start = 1'b0; cfg_we = 1'b0;
    m_chg = 0; m_sig = '0; have_prev = 0; prev = '0;
    for (int t = 1; t <= tend; t++) begin
      if (!lb && $urandom_range(2) == 0) ext_out = {$urandom, $urandom};
      cur = lb ? exp_in() : ext_out;
      if (have_prev && cur != prev) begin
        m_chg++;
        m_sig = rol32(m_sig, 1) ^ cur[31:0] ^ rol32(cur[63:32], 1);
      end
      prev = cur; have_prev = 1;
      if (t == bad_t) drive_cfg(0, 0, $urandom, $urandom, 1);
      tick();
      cfg_we = 1'b0;
      eu = '0;
      for (int k = 0; k < N_CH; k++) begin
        if ((len == 0 || t <= p0 * len) && (t % m_per[k] == 0)) begin
          m_val[k] = next_val(m_mode[k], m_val[k], m_step[k]);
          eu[k] = 1'b1;
        end
      end
      check("upd", 64'(upd), 64'(eu));
      check("in_port", in_port, exp_in());
      check("busy", 64'(busy), 64'(len == 0 || t < tend));
      check("done", 64'(done), 64'(len != 0 && t == tend));
      check("cfg_err_run", 64'(cfg_err), 64'(t == bad_t));
    end
    check("chg_cnt", 64'(chg_cnt), 64'(m_chg));
    check("signature", 64'(signature), 64'(m_sig));
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    reset = 1'b0;
    check("rst_in_port", in_port, exp_in());
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_upd", 64'(upd), 64'd0);
    check("rst_chg", 64'(chg_cnt), 64'd0);
    check("rst_sig", 64'(signature), 64'd0);
    check("rst_cfg_err", 64'(cfg_err), 64'd0);
    check("rst_in_vals", in_port, 64'h0000_0001_0000_0000);

    // default patterns, three ch0 updates
    tick();
    run(3, 0, 0, 0);
    check("t1_ch0_final", 64'(in_port[31:0]), 64'd3);
    check("t1_ch1_final", 64'(in_port[63:32]), 64'd4);

    // ch0 LFSR with zero seed at period 1
    cfg_write(0, 2, 32'd0, 32'd0, 1);
    check("t2_seed", 64'(in_port[31:0]), 64'd1);
    run(2, 0, 0, 0);

    // ch1 DEC step 2 from 1 with period 0
    cfg_write(1, 3, 32'd2, 32'd1, 0);
    run(2, 0, 0, 0);
    check("t3_ch1_final", 64'(in_port[63:32]), 64'hFFFF_FFFD);

    // rejected config: bad channel while idle, and any write during a run
    cfg_write(5, 1, 32'd7, 32'd9, 3);
    run(3, 0, 0, 2);

    // loopback with default configuration
    reset = 1'b1; tick(); reset = 1'b0; model_reset();
    run(4, 1, 0, 0);
    check("t5_chg_cnt", 64'(chg_cnt), 64'd4);

    // randomized configurations and runs
    for (int it = 0; it < 20; it++) begin
      int ch;
      ch = $urandom_range(7);
      cfg_write(ch, $urandom_range(3), $urandom, ($urandom_range(3) == 0) ? 32'd0 : $urandom,
                $urandom_range(6));
      if ($urandom_range(1) == 1) begin
        ch = $urandom_range(N_CH - 1);
        drive_cfg(ch, $urandom_range(3), $urandom, $urandom, $urandom_range(6));
        model_cfg(ch, int'(cfg_mode), cfg_step, cfg_seed, int'(cfg_period));
      end
      run($urandom_range(1, 4), 1'($urandom_range(1)), 0, 0);
    end

    // reset in the middle of an open-ended run
    reset = 1'b1; tick(); reset = 1'b0; model_reset();
    run(0, 1, 11, 0);
    check("t6_chg_before", 64'(chg_cnt), 64'd2);
    reset = 1'b1; tick(); reset = 1'b0; model_reset();
    check("t6_in_port", in_port, 64'h0000_0001_0000_0000);
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_chg", 64'(chg_cnt), 64'd0);
    check("t6_sig", 64'(signature), 64'd0);
    check("t6_upd", 64'(upd), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
